// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings for the two-master arbiter and its testbench.
package ahb3lite_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } hresp_t;

  localparam int NUM_MASTERS = 2;

endpackage

// File: rtl/ahb3lite_arb2.sv
// Two-master AHB3-Lite arbiter/mux in front of a single slave. The grant moves
// only when the owner is IDLE; data phase is steered back to its address owner.
module ahb3lite_arb2
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,

  input  logic [HADDR_SIZE-1:0] M0_HADDR,
  input  logic [HDATA_SIZE-1:0] M0_HWDATA,
  input  logic                  M0_HWRITE,
  input  logic [2:0]            M0_HSIZE,
  input  logic [2:0]            M0_HBURST,
  input  logic [3:0]            M0_HPROT,
  input  logic [1:0]            M0_HTRANS,
  output logic                  M0_HREADY,
  output logic                  M0_HRESP,
  output logic [HDATA_SIZE-1:0] M0_HRDATA,

  input  logic [HADDR_SIZE-1:0] M1_HADDR,
  input  logic [HDATA_SIZE-1:0] M1_HWDATA,
  input  logic                  M1_HWRITE,
  input  logic [2:0]            M1_HSIZE,
  input  logic [2:0]            M1_HBURST,
  input  logic [3:0]            M1_HPROT,
  input  logic [1:0]            M1_HTRANS,
  output logic                  M1_HREADY,
  output logic                  M1_HRESP,
  output logic [HDATA_SIZE-1:0] M1_HRDATA,

  output logic                  S_HSEL,
  output logic [HADDR_SIZE-1:0] S_HADDR,
  output logic [HDATA_SIZE-1:0] S_HWDATA,
  output logic                  S_HWRITE,
  output logic [2:0]            S_HSIZE,
  output logic [2:0]            S_HBURST,
  output logic [3:0]            S_HPROT,
  output logic [1:0]            S_HTRANS,
  output logic                  S_HREADY,
  input  logic                  S_HREADYOUT,
  input  logic                  S_HRESP,
  input  logic [HDATA_SIZE-1:0] S_HRDATA
);

  logic aown;
  logic down;
  logic dvalid;

  logic [HADDR_SIZE-1:0] m_haddr  [NUM_MASTERS];
  logic [HDATA_SIZE-1:0] m_hwdata [NUM_MASTERS];
  logic                  m_hwrite [NUM_MASTERS];
  logic [2:0]            m_hsize  [NUM_MASTERS];
  logic [2:0]            m_hburst [NUM_MASTERS];
  logic [3:0]            m_hprot  [NUM_MASTERS];
  logic [1:0]            m_htrans [NUM_MASTERS];
  logic                  m_hready [NUM_MASTERS];
  logic                  m_hresp  [NUM_MASTERS];
  logic [HDATA_SIZE-1:0] m_hrdata [NUM_MASTERS];

  logic [1:0] own_trans;
  logic [1:0] other_trans;
  logic       handover;

  assign m_haddr[0]  = M0_HADDR;
  assign m_hwdata[0] = M0_HWDATA;
  assign m_hwrite[0] = M0_HWRITE;
  assign m_hsize[0]  = M0_HSIZE;
  assign m_hburst[0] = M0_HBURST;
  assign m_hprot[0]  = M0_HPROT;
  assign m_htrans[0] = M0_HTRANS;

  assign m_haddr[1]  = M1_HADDR;
  assign m_hwdata[1] = M1_HWDATA;
  assign m_hwrite[1] = M1_HWRITE;
  assign m_hsize[1]  = M1_HSIZE;
  assign m_hburst[1] = M1_HBURST;
  assign m_hprot[1]  = M1_HPROT;
  assign m_htrans[1] = M1_HTRANS;

  assign own_trans   = m_htrans[aown];
  assign other_trans = m_htrans[~aown];
  // Only an idle owner yields, so an in-flight burst is never split.
  assign handover    = (own_trans == IDLE) && (other_trans == NONSEQ);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      aown   <= 1'b0;
      down   <= 1'b0;
      dvalid <= 1'b0;
    end else if (S_HREADYOUT) begin
      down   <= aown;
      dvalid <= own_trans[1];
      if (handover) begin
        aown <= ~aown;
      end
    end
  end

  assign S_HSEL   = (own_trans != IDLE);
  assign S_HADDR  = m_haddr[aown];
  assign S_HWRITE = m_hwrite[aown];
  assign S_HSIZE  = m_hsize[aown];
  assign S_HBURST = m_hburst[aown];
  assign S_HPROT  = m_hprot[aown];
  assign S_HTRANS = own_trans;
  assign S_HWDATA = m_hwdata[down];
  assign S_HREADY = S_HREADYOUT;

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
    logic is_aowner;
    logic is_downer;

    assign is_aowner = (aown == 1'(gi));
    assign is_downer = dvalid && (down == 1'(gi));

    // A master with no stake on the bus sees ready only while it is idle.
    assign m_hready[gi] = (is_aowner || is_downer) ? S_HREADYOUT
                                                   : (m_htrans[gi] == IDLE);
    assign m_hresp[gi]  = is_downer ? S_HRESP  : OKAY;
    assign m_hrdata[gi] = is_downer ? S_HRDATA : '0;
  end

  assign M0_HREADY = m_hready[0];
  assign M0_HRESP  = m_hresp[0];
  assign M0_HRDATA = m_hrdata[0];
  assign M1_HREADY = m_hready[1];
  assign M1_HRESP  = m_hresp[1];
  assign M1_HRDATA = m_hrdata[1];

endmodule

// File: tb/tb_ahb3lite_arb2.sv
// Directed bench for ahb3lite_arb2 with a small SRAM slave model and a queue scoreboard.
module tb_ahb3lite_arb2;
  import ahb3lite_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] m0_haddr, m0_hwdata, m0_hrdata, m1_haddr, m1_hwdata, m1_hrdata;
  logic        m0_hwrite, m0_hready, m0_hresp, m1_hwrite, m1_hready, m1_hresp;
  logic [2:0]  m0_hsize, m0_hburst, m1_hsize, m1_hburst;
  logic [3:0]  m0_hprot, m1_hprot;
  logic [1:0]  m0_htrans, m1_htrans;

  logic        s_hsel, s_hwrite, s_hready, s_hreadyout, s_hresp;
  logic [31:0] s_haddr, s_hwdata, s_hrdata;
  logic [2:0]  s_hsize, s_hburst;
  logic [3:0]  s_hprot;
  logic [1:0]  s_htrans;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  logic [31:0] mem [0:63];
  logic        dph_valid, dph_write;
  logic [31:0] dph_addr;

  ahb3lite_arb2 #(.HADDR_SIZE(32), .HDATA_SIZE(32)) dut (
    .HCLK(clk), .HRESET(rst),
    .M0_HADDR(m0_haddr), .M0_HWDATA(m0_hwdata), .M0_HWRITE(m0_hwrite),
    .M0_HSIZE(m0_hsize), .M0_HBURST(m0_hburst), .M0_HPROT(m0_hprot),
    .M0_HTRANS(m0_htrans), .M0_HREADY(m0_hready), .M0_HRESP(m0_hresp),
    .M0_HRDATA(m0_hrdata),
    .M1_HADDR(m1_haddr), .M1_HWDATA(m1_hwdata), .M1_HWRITE(m1_hwrite),
    .M1_HSIZE(m1_hsize), .M1_HBURST(m1_hburst), .M1_HPROT(m1_hprot),
    .M1_HTRANS(m1_htrans), .M1_HREADY(m1_hready), .M1_HRESP(m1_hresp),
    .M1_HRDATA(m1_hrdata),
    .S_HSEL(s_hsel), .S_HADDR(s_haddr), .S_HWDATA(s_hwdata), .S_HWRITE(s_hwrite),
    .S_HSIZE(s_hsize), .S_HBURST(s_hburst), .S_HPROT(s_hprot), .S_HTRANS(s_htrans),
    .S_HREADY(s_hready), .S_HREADYOUT(s_hreadyout), .S_HRESP(s_hresp),
    .S_HRDATA(s_hrdata)
  );

  // SRAM slave model: captures the address phase, writes/reads in the data phase.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dph_valid <= 1'b0;
      dph_write <= 1'b0;
      dph_addr  <= '0;
    end else if (s_hreadyout) begin
      if (dph_valid && dph_write) mem[dph_addr[7:2]] <= s_hwdata;
      dph_valid <= s_hsel && s_hready && s_htrans[1];
      dph_write <= s_hwrite;
      dph_addr  <= s_haddr;
    end
  end
  assign s_hrdata = (dph_valid && !dph_write) ? mem[dph_addr[7:2]] : 32'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    chk(tag, {32'h0, obs}, {32'h0, e});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_m0(input logic [1:0] t, input logic [31:0] a, input logic w, input logic [2:0] b);
    m0_htrans = t; m0_haddr = a; m0_hwrite = w; m0_hburst = b;
  endtask

  task automatic drv_m1(input logic [1:0] t, input logic [31:0] a, input logic w, input logic [2:0] b);
    m1_htrans = t; m1_haddr = a; m1_hwrite = w; m1_hburst = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    m0_hsize = 3'd2; m1_hsize = 3'd2; m0_hprot = 4'h3; m1_hprot = 4'h3;
    m0_hwdata = '0; m1_hwdata = '0;
    drv_m0(IDLE, 32'h0, 1'b0, 3'd0);
    drv_m1(IDLE, 32'h0, 1'b0, 3'd0);
    s_hreadyout = 1'b1; s_hresp = OKAY;
    #1;
    $display("step reset");
    chk("rst_aown", 64'(dut.aown), 64'd0);
    chk("rst_dvalid", 64'(dut.dvalid), 64'd0);
    chk("rst_m0_hrdata", 64'(m0_hrdata), 64'd0);
    chk("rst_m1_hresp", 64'(m1_hresp), 64'd0);
    chk("rst_m1_hready_idle", 64'(m1_hready), 64'd1);
    m1_htrans = NONSEQ; m0_htrans = BUSY; #1;
    chk("rst_m1_hready_active", 64'(m1_hready), 64'd0);
    chk("rst_s_htrans_m0", 64'(s_htrans), 64'(BUSY));
    drv_m0(IDLE, 32'h0, 1'b0, 3'd0);
    drv_m1(IDLE, 32'h0, 1'b0, 3'd0);
    @(negedge clk) rst = 1'b0;

    // M0 single write 0xDEADBEEF to 0x4
    tick(); $display("step m0 write addr 0x4");
    drv_m0(NONSEQ, 32'h4, 1'b1, 3'd0); #1;
    chk("t1_s_haddr", 64'(s_haddr), 64'h4);
    chk("t1_s_hsel", 64'(s_hsel), 64'd1);
    chk("t1_m1_hready", 64'(m1_hready), 64'd1);
    exp_q.push_back(32'hDEADBEEF);
    tick(); $display("step m0 write data");
    drv_m0(IDLE, 32'h0, 1'b0, 3'd0); m0_hwdata = 32'hDEADBEEF; #1;
    chk_pop("t1_s_hwdata", s_hwdata);
    chk("t1_dvalid", 64'(dut.dvalid), 64'd1);
    chk("t1_m1_hready_data", 64'(m1_hready), 64'd1);

    // M0 INCR4 write from 0x10 while M1 waits with NONSEQ to 0x20
    for (int i = 0; i < 4; i++) begin
      tick(); $display("step m0 incr4 beat %0d", i);
      drv_m0(i == 0 ? NONSEQ : SEQ, 32'h10 + 32'(4 * i), 1'b1, 3'b011);
      drv_m1(NONSEQ, 32'h20, 1'b1, 3'd0);
      if (i > 0) m0_hwdata = 32'hA000_0000 + 32'(i - 1);
      #1;
      if (i > 0) chk_pop("t2_s_hwdata", s_hwdata);
      chk("t2_m1_hready_stall", 64'(m1_hready), 64'd0);
      chk("t2_s_haddr", 64'(s_haddr), 64'h10 + 64'(4 * i));
      exp_q.push_back(32'hA000_0000 + 32'(i));
    end
    tick(); $display("step m0 idle, last data");
    drv_m0(IDLE, 32'h0, 1'b0, 3'd0); m0_hwdata = 32'hA000_0003; #1;
    chk_pop("t2_s_hwdata_last", s_hwdata);
    chk("t2_s_hsel_idle", 64'(s_hsel), 64'd0);
    chk("t2_m1_hready_idlecyc", 64'(m1_hready), 64'd0);
    tick(); $display("step m1 granted addr 0x20");
    #1;
    chk("t2_aown", 64'(dut.aown), 64'd1);
    chk("t2_s_haddr_m1", 64'(s_haddr), 64'h20);
    chk("t2_s_htrans_m1", 64'(s_htrans), 64'(NONSEQ));
    chk("t2_m1_hready_go", 64'(m1_hready), 64'd1);
    chk("t2_m0_hready_idle", 64'(m0_hready), 64'd1);
    exp_q.push_back(32'hCAFEF00D);
    tick(); $display("step m1 write data");
    drv_m1(IDLE, 32'h0, 1'b0, 3'd0); m1_hwdata = 32'hCAFEF00D; #1;
    chk_pop("t2_s_hwdata_m1", s_hwdata);

    // M0 writes 0x11223344 to 0x8, then M1 reads it back
    tick(); $display("step m0 request while parked on m1");
    drv_m0(NONSEQ, 32'h8, 1'b1, 3'd0); #1;
    chk("t3_m0_hready_stall", 64'(m0_hready), 64'd0);
    chk("t3_s_htrans_idle", 64'(s_htrans), 64'(IDLE));
    tick(); $display("step m0 write addr 0x8");
    #1;
    chk("t3_s_haddr", 64'(s_haddr), 64'h8);
    chk("t3_m0_hready", 64'(m0_hready), 64'd1);
    exp_q.push_back(32'h11223344);
    tick(); $display("step m0 write data, m1 read request");
    drv_m0(IDLE, 32'h0, 1'b0, 3'd0); m0_hwdata = 32'h11223344;
    drv_m1(NONSEQ, 32'h8, 1'b0, 3'd0); #1;
    chk_pop("t3_s_hwdata", s_hwdata);
    chk("t3_m1_hready_wait", 64'(m1_hready), 64'd0);
    tick(); $display("step m1 read addr 0x8");
    #1;
    chk("t3_s_haddr_m1", 64'(s_haddr), 64'h8);
    chk("t3_s_hwrite", 64'(s_hwrite), 64'd0);
    exp_q.push_back(32'h11223344);
    tick(); $display("step m1 read data");
    drv_m1(IDLE, 32'h0, 1'b0, 3'd0); #1;
    chk_pop("t3_m1_hrdata", m1_hrdata);
    chk("t3_m0_hrdata_zero", 64'(m0_hrdata), 64'd0);

    // Two wait states on M1's data phase while M0 requests
    tick(); $display("step m1 read addr 0x4");
    drv_m1(NONSEQ, 32'h4, 1'b0, 3'd0); #1;
    exp_q.push_back(32'hDEADBEEF);
    for (int w = 0; w < 2; w++) begin
      tick(); $display("step wait state %0d", w);
      drv_m1(IDLE, 32'h0, 1'b0, 3'd0);
      drv_m0(NONSEQ, 32'h30, 1'b1, 3'd0);
      s_hreadyout = 1'b0; #1;
      chk("t4_m1_hready_low", 64'(m1_hready), 64'd0);
      chk("t4_m0_hready_low", 64'(m0_hready), 64'd0);
      chk("t4_aown_hold", 64'(dut.aown), 64'd1);
    end
    tick(); $display("step m1 read data after waits");
    s_hreadyout = 1'b1; #1;
    chk("t4_m1_hready_done", 64'(m1_hready), 64'd1);
    chk_pop("t4_m1_hrdata", m1_hrdata);
    chk("t4_m0_hready_stall", 64'(m0_hready), 64'd0);
    tick(); $display("step m0 write addr 0x30");
    #1;
    chk("t4_aown_m0", 64'(dut.aown), 64'd0);
    chk("t4_s_haddr", 64'(s_haddr), 64'h30);
    exp_q.push_back(32'h55AA55AA);
    tick(); $display("step m0 write data 0x30");
    drv_m0(IDLE, 32'h0, 1'b0, 3'd0); m0_hwdata = 32'h55AA55AA; #1;
    chk_pop("t4_s_hwdata", s_hwdata);

    // Idle-parked handover to M1, then reset during its burst
    tick(); $display("step both idle");
    #1;
    chk("t5_dvalid_idle", 64'(dut.dvalid), 64'd0);
    tick(); $display("step m1 nonseq burst 0x10");
    drv_m1(NONSEQ, 32'h10, 1'b0, 3'b011); #1;
    chk("t5_aown_before", 64'(dut.aown), 64'd0);
    chk("t5_dvalid_before", 64'(dut.dvalid), 64'd0);
    tick(); $display("step m1 granted");
    #1;
    chk("t5_aown_after", 64'(dut.aown), 64'd1);
    chk("t5_dvalid_after", 64'(dut.dvalid), 64'd0);
    chk("t5_s_haddr", 64'(s_haddr), 64'h10);
    chk("t5_m1_hready", 64'(m1_hready), 64'd1);
    exp_q.push_back(32'hA000_0000);
    tick(); $display("step m1 beat 2, reset asserted");
    drv_m1(SEQ, 32'h14, 1'b0, 3'b011);
    drv_m0(NONSEQ, 32'h40, 1'b0, 3'd0); #1;
    chk_pop("t6_m1_hrdata", m1_hrdata);
    chk("t6_dvalid_pre", 64'(dut.dvalid), 64'd1);
    rst = 1'b1; #1;
    chk("t6_aown_rst", 64'(dut.aown), 64'd0);
    chk("t6_dvalid_rst", 64'(dut.dvalid), 64'd0);
    chk("t6_s_htrans_m0", 64'(s_htrans), 64'(NONSEQ));
    chk("t6_s_haddr_m0", 64'(s_haddr), 64'h40);
    chk("t6_m1_hrdata_zero", 64'(m1_hrdata), 64'd0);
    chk("t6_m1_hready_stall", 64'(m1_hready), 64'd0);
    drv_m0(IDLE, 32'h0, 1'b0, 3'd0);
    drv_m1(IDLE, 32'h0, 1'b0, 3'd0);
    @(negedge clk) rst = 1'b0;
    tick();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb3lite_arb2.md
# ahb3lite_arb2

Two-master AHB3-Lite arbiter and bus multiplexer in front of the single-port SRAM slave `ahb3lite_sram1rw`. It lets two AHB3-Lite masters (M0, M1) share the slave.
- Ownership of the address phase changes only at IDLE boundaries, so bursts are never broken.
- The data phase is routed back to whichever master owned the preceding address phase.
- A non-owning master is stalled through its HREADY until it is granted.

## Interface
- `HADDR_SIZE`, default 32: address width.
- `HDATA_SIZE`, default 32: data width.
- Clocking: one clock `HCLK`; reset `HRESET` is asynchronous and active-high.
- `HCLK` in 1: bus clock.
- `HRESET` in 1: asynchronous active-high reset.
- `Mx_HADDR` in HADDR_SIZE; `Mx_HWDATA` in HDATA_SIZE; `Mx_HWRITE` in 1; `Mx_HSIZE` in 3; `Mx_HBURST` in 3; `Mx_HPROT` in 4; `Mx_HTRANS` in 2. These are master x request signals, x ∈ {0,1}.
- `Mx_HREADY` out 1; `Mx_HRESP` out 1; `Mx_HRDATA` out HDATA_SIZE. These are master x response signals.
- `S_HSEL` out 1; `S_HADDR`, `S_HWDATA`, `S_HWRITE`, `S_HSIZE`, `S_HBURST`, `S_HPROT`, `S_HTRANS` out. These are the muxed slave request signals, same widths as the master side.
- `S_HREADY` out 1: slave HREADY input, tied to `S_HREADYOUT`.
- `S_HREADYOUT` in 1; `S_HRESP` in 1; `S_HRDATA` in HDATA_SIZE. These are slave responses.

## Operation
State registers:
- `aown` (1 bit): address-phase owner.
- `down` (1 bit): data-phase owner.
- `dvalid` (1 bit): the current data phase belongs to a real transfer.

Slave request path:
- All `S_*` request signals are muxed from master `aown`. `S_HWDATA` is muxed from master `down`.
- `S_HSEL` = (`Maown_HTRANS` != IDLE).

Grant update, evaluated at a posedge with `S_HREADYOUT` = 1:
- If `Maown_HTRANS` == IDLE and `M(~aown)_HTRANS` == NONSEQ, then `aown` <= ~aown.
- Otherwise `aown` holds. This parks the grant on the last owner.
- The owner presenting NONSEQ, SEQ or BUSY always keeps the bus. There is no preemption.

Data-phase tracking, evaluated at a posedge with `S_HREADYOUT` = 1:
- `down` <= `aown`.
- `dvalid` <= `Maown_HTRANS[1]`, i.e. the owner's transfer is NONSEQ or SEQ.

`Mx_HREADY`:
- `S_HREADYOUT` if x == `aown` or (`dvalid` and x == `down`).
- Otherwise 1 if `Mx_HTRANS` == IDLE.
- Otherwise 0, i.e. stalled. A stalled master holds its address and control per protocol.

`Mx_HRESP` and `Mx_HRDATA`:
- `S_HRESP` and `S_HRDATA` when `dvalid` and x == `down`.
- Otherwise `Mx_HRESP` = 0 (OKAY) and `Mx_HRDATA` = 0.

ERROR response:
- The two-cycle ERROR response passes through to the data owner unchanged.
- If that master then drives IDLE, a waiting master may be granted on the ERROR's second cycle.

## Timing
- The mux path is combinational, giving zero added latency for the owner.
- Handover costs exactly one IDLE address cycle: the old owner's IDLE is forwarded, and the new owner's NONSEQ reaches the slave the following cycle.
- With `S_HREADYOUT` = 0 no register changes, and both the current owner and the data owner see HREADY low.
- Reset values: `aown` = 0, `down` = 0, `dvalid` = 0.
  - Consequently `S_HTRANS` = M0_HTRANS, `Mx_HRESP` = 0 and `Mx_HRDATA` = 0.
  - `M1_HREADY` = 0 if M1 is non-IDLE, else 1.
- Reset asserted mid-transfer aborts immediately. Ownership returns to M0, and no data phase is reported.
- Simultaneous NONSEQ from both masters while the owner is idle-parked: the owner wins, because it is not IDLE.

## Structure
- Package `ahb3lite_pkg` holds the HTRANS constants (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11) and the HRESP constants (OKAY=0, ERROR=1). It is shared with the testbench.
- Single module with no sub-modules. The three registers and the muxing fit in one always_ff plus combinational assigns.

## Test plan
- Reset, then M0 writes 0xDEADBEEF to 0x4 (SINGLE, HSIZE=2). Required: `S_HADDR`=0x4 in the address phase, `S_HWDATA`=0xDEADBEEF in the next cycle, `M1_HREADY`=1 while M1 is IDLE.
- M0 runs a 4-beat INCR from 0x10 while M1 drives NONSEQ to 0x20. Required: `M1_HREADY`=0 for all 4 beats; M1's address appears on the slave on the cycle after M0's first IDLE.
- M0 writes 0x11223344 to 0x8, then M1 reads 0x8. Required: `M1_HRDATA`=0x11223344, and `M0_HRDATA` stays 0 in that data phase.
- Slave inserts 2 wait states on M1's data phase while M0 requests. Required: `M1_HREADY` and `M0_HREADY` are both low for 2 cycles, and `aown` is unchanged.
- Both masters IDLE, then M1 issues NONSEQ. Required: grant moves to M1 at the next edge, and `dvalid`=0 throughout the handover.
- Assert `HRESET` during M1's burst beat 2. Required: `aown`=0 and `dvalid`=0 immediately; `S_HTRANS` follows M0.
